// File: rtl/lshift_pkg.sv
// Shared constants and types for the lshift_4 barrel shifter.
package lshift_pkg;

  localparam int LSHIFT_WIDTH = 4;

  typedef logic [$clog2(LSHIFT_WIDTH)-1:0] shamt_t;

  function automatic bit is_pow2(input int w);
    return (w >= 2) && ((w & (w - 1)) == 0);
  endfunction

endpackage

// File: rtl/lshift_4_if.sv
// Operand/result bundle for lshift_4; the rot signal exists only when LSHIFT_4_ROTATE_EN is defined.
interface lshift_4_if #(
  parameter int WIDTH = lshift_pkg::LSHIFT_WIDTH
);
  localparam int SHW = $clog2(WIDTH);

  // Valid-only handshake: in_valid qualifies A/shl/rot for one cycle and there is no ready;
  // out_valid pulses exactly one cycle later and results stay held until the next valid input.
  logic             in_valid;
  logic [WIDTH-1:0] A;
  logic [SHW-1:0]   shl;
`ifdef LSHIFT_4_ROTATE_EN
  logic             rot;
`endif
  logic             out_valid;
  logic [WIDTH-1:0] OUT;
  logic [WIDTH-1:0] spill;
  logic             zero;

`ifdef LSHIFT_4_ROTATE_EN
  modport master (output in_valid, A, shl, rot, input out_valid, OUT, spill, zero);
  modport slave  (input in_valid, A, shl, rot, output out_valid, OUT, spill, zero);
`else
  modport master (output in_valid, A, shl, input out_valid, OUT, spill, zero);
  modport slave  (input in_valid, A, shl, output out_valid, OUT, spill, zero);
`endif

endinterface

// File: rtl/lshift_stage.sv
// One conditional fixed-distance shift stage over a {hi, lo} pair, where hi collects the
// bits pushed out of lo. With rot set the pushed-out bits also wrap into the bottom of lo.
module lshift_stage #(
  parameter int WIDTH = 4,
  parameter int DIST  = 1
) (
  input  logic             en,
  input  logic             rot,
  input  logic [WIDTH-1:0] lo_i,
  input  logic [WIDTH-1:0] hi_i,
  output logic [WIDTH-1:0] lo_o,
  output logic [WIDTH-1:0] hi_o
);

  logic [WIDTH-1:0] top_bits;

  always_comb begin
    top_bits = lo_i >> (WIDTH - DIST);
    lo_o     = lo_i;
    hi_o     = hi_i;
    if (en) begin
      hi_o = (hi_i << DIST) | top_bits;
      lo_o = (lo_i << DIST) | (rot ? top_bits : '0);
    end
  end

endmodule

// File: rtl/lshift_4.sv
// Registered left barrel shifter with spill and zero flags, one cycle latency.
// Optional rotate mode is enabled by defining LSHIFT_4_ROTATE_EN.
module lshift_4
  import lshift_pkg::*;
#(
  parameter  int WIDTH = LSHIFT_WIDTH,
  localparam int SHW   = $clog2(WIDTH)
) (
  input logic       clk,
  input logic       reset,
  lshift_4_if.slave bus
);

  if (!is_pow2(WIDTH)) begin : g_bad_width
    $error("lshift_4: WIDTH must be a power of two and at least 2");
  end

  logic                      rot_sel;
  logic [SHW:0][WIDTH-1:0]   lo_s;
  logic [SHW:0][WIDTH-1:0]   hi_s;

`ifdef LSHIFT_4_ROTATE_EN
  assign rot_sel = bus.rot;
`else
  assign rot_sel = 1'b0;
`endif

  assign lo_s[0] = bus.A;
  assign hi_s[0] = '0;

  // Stage k moves by 2^k; hi accumulates A >> (WIDTH - shl) as the stages cascade.
  for (genvar k = 0; k < SHW; k++) begin : g_stage
    lshift_stage #(
      .WIDTH (WIDTH),
      .DIST  (1 << k)
    ) u_stage (
      .en   (bus.shl[k]),
      .rot  (rot_sel),
      .lo_i (lo_s[k]),
      .hi_i (hi_s[k]),
      .lo_o (lo_s[k+1]),
      .hi_o (hi_s[k+1])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bus.out_valid <= 1'b0;
      bus.OUT       <= '0;
      bus.spill     <= '0;
      bus.zero      <= 1'b1;
    end else begin
      bus.out_valid <= bus.in_valid;
      if (bus.in_valid) begin
        bus.OUT   <= lo_s[SHW];
        bus.spill <= hi_s[SHW];
        bus.zero  <= (lo_s[SHW] == '0);
      end
    end
  end

endmodule

// File: tb/tb_lshift_4.sv
// Self-checking bench for lshift_4: directed cases plus randomized traffic against an arithmetic model.
module tb_lshift_4;
  import lshift_pkg::*;

  localparam int W = LSHIFT_WIDTH;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_errors;
  logic [2*W+1:0] exp_q[$];

  // Model state: what the outputs should hold after the most recent edge.
  logic         m_valid;
  logic         m_zero;
  logic [W-1:0] m_out;
  logic [W-1:0] m_spill;

  lshift_4_if #(.WIDTH(W)) bus ();

  lshift_4 #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Shift/rotate computed on plain integers from the operand, amount and mode.
  task automatic model_calc(input int a, input int s, input bit r,
                            output logic [W-1:0] o, output logic [W-1:0] sp);
    int mask;
    int full;
    mask = (1 << W) - 1;
    full = a << s;
    sp   = (s == 0) ? '0 : W'(a >> (W - s));
    if (r && s != 0) o = W'((full | (a >> (W - s))) & mask);
    else             o = W'(full & mask);
  endtask

  task automatic step(input bit v, input int a, input int s, input bit r, input bit rst);
    logic [W-1:0] o, sp;
    logic [2*W+1:0] e;
    @(negedge clk);
    reset        = rst;
    bus.in_valid = v;
    bus.A        = W'(a);
    bus.shl      = shamt_t'(s);
`ifdef LSHIFT_4_ROTATE_EN
    bus.rot      = r;
`else
    r = 1'b0;
`endif
    if (rst) begin
      m_valid = 1'b0; m_out = '0; m_spill = '0; m_zero = 1'b1;
    end else begin
      m_valid = v;
      if (v) begin
        model_calc(a, s, r, o, sp);
        m_out = o; m_spill = sp; m_zero = (o == 0);
      end
    end
    exp_q.push_back({m_valid, m_zero, m_spill, m_out});
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check("out_valid", 32'(bus.out_valid), 32'(e[2*W+1]));
    check("zero",      32'(bus.zero),      32'(e[2*W]));
    check("spill",     32'(bus.spill),     32'(e[2*W-1:W]));
    check("out",       32'(bus.OUT),       32'(e[W-1:0]));
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    reset = 1'b1;
    bus.in_valid = 1'b0;
    bus.A = '0;
    bus.shl = '0;
`ifdef LSHIFT_4_ROTATE_EN
    bus.rot = 1'b0;
`endif
    m_valid = 1'b0; m_zero = 1'b1; m_out = '0; m_spill = '0;

    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    check("rst_out", 32'(bus.OUT), 32'h0);
    check("rst_zero", 32'(bus.zero), 32'h1);

    step(1, 'h3, 2, 0, 0);
    check("d27_out", 32'(bus.OUT), 32'hC);
    check("d27_spill", 32'(bus.spill), 32'h0);
    step(1, 'hF, 3, 0, 0);
    check("d28a_out", 32'(bus.OUT), 32'h8);
    check("d28a_spill", 32'(bus.spill), 32'h7);
    step(1, 'h9, 0, 0, 0);
    check("d28b_out", 32'(bus.OUT), 32'h9);
    check("d28b_spill", 32'(bus.spill), 32'h0);
    step(1, 'h8, 1, 0, 0);
    check("d29_out", 32'(bus.OUT), 32'h0);
    check("d29_zero", 32'(bus.zero), 32'h1);
    check("d29_spill", 32'(bus.spill), 32'h1);

    // Reset while a result is held, then reset alongside a valid input.
    step(1, 'h3, 1, 0, 0);
    step(0, 0, 0, 0, 1);
    check("d22_out", 32'(bus.OUT), 32'h0);
    step(1, 'h5, 1, 0, 1);
    check("d30_out", 32'(bus.OUT), 32'h0);
    check("d30_valid", 32'(bus.out_valid), 32'h0);
    check("d30_zero", 32'(bus.zero), 32'h1);

    step(1, 'h1, 1, 0, 0);
    check("d31_r0", 32'(bus.OUT), 32'h2);
    step(1, 'h2, 2, 0, 0);
    check("d31_r1", 32'(bus.OUT), 32'h8);
    step(1, 'h7, 3, 0, 0);
    check("d31_r2", 32'(bus.OUT), 32'h8);
    check("d31_r2_spill", 32'(bus.spill), 32'h3);
    step(0, 'h1, 1, 0, 0);
    step(0, 'h6, 2, 0, 0);
    check("d31_hold", 32'(bus.OUT), 32'h8);
    check("d31_hold_valid", 32'(bus.out_valid), 32'h0);

`ifdef LSHIFT_4_ROTATE_EN
    step(1, 'h9, 1, 1, 0);
    check("d32_out", 32'(bus.OUT), 32'h3);
    check("d32_spill", 32'(bus.spill), 32'h1);
`endif

    for (int i = 0; i < 300; i++) begin
      step(bit'($urandom_range(0, 3) != 0), int'($urandom_range(0, (1 << W) - 1)),
           int'($urandom_range(0, W - 1)), bit'($urandom_range(0, 1)),
           bit'($urandom_range(0, 19) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/lshift_4.md
LSHIFT_4 -- requirements
Module: lshift_4

Interface
REQ-001 Parameter WIDTH, default 4, data width in bits; SHALL be a power of two, at least 2.
REQ-002 Parameter SHW, default $clog2(WIDTH) = 2, shift-amount width; SHALL be derived from WIDTH and never overridden.
REQ-003 clk, input, 1, single clock; all state updates on its rising edge.
REQ-004 reset, input, 1, synchronous, active-high.
REQ-005 in_valid, input, 1, qualifies A and shl in the current cycle.
REQ-006 A, input, WIDTH, operand to shift.
REQ-007 shl, input, SHW, left-shift amount, 0..WIDTH-1.
REQ-008 out_valid, output, 1, OUT/spill/zero hold a result.
REQ-009 OUT, output, WIDTH, shifted result.
REQ-010 spill, output, WIDTH, bits shifted out of the top, right-aligned.
REQ-011 zero, output, 1, high when OUT is all zeros.

Function
REQ-012 OUT SHALL equal (A << shl) truncated to WIDTH bits, with zeros filled in from the LSB side.
REQ-013 spill SHALL equal A >> (WIDTH - shl) when shl is nonzero, and 0 when shl is 0.
REQ-014 Latency SHALL be exactly 1 cycle: inputs sampled on the edge where in_valid is 1; OUT, spill, zero and out_valid are updated on that same edge.
REQ-015 out_valid SHALL be a registered copy of in_valid; there is no backpressure.
REQ-016 When in_valid is 0, OUT, spill and zero SHALL hold their previous values.
REQ-017 shl = 0 SHALL pass A through unchanged with spill = 0.
REQ-018 Back-to-back valid inputs SHALL produce back-to-back results, one per cycle, in order.
REQ-019 The shift SHALL be built as SHW cascaded stages, where stage k shifts by 2^k when shl[k] is set.

Reset
REQ-020 While reset is 1 at a clock edge, OUT, spill and out_valid SHALL become 0 and zero SHALL become 1, regardless of in_valid.
REQ-021 A valid input present in the same cycle as reset SHALL be discarded.
REQ-022 Reset asserted while a result is held SHALL clear it on the next edge.

Configuration
REQ-023 Macro LSHIFT_4_ROTATE_EN: when defined, an extra input rot (1 bit) is added. When rot is 1, OUT SHALL equal A rotated left by shl, and spill SHALL still report the wrapped bits.
REQ-024 When LSHIFT_4_ROTATE_EN is undefined, the rot port SHALL NOT exist and behaviour is the logical shift only.

Structure
REQ-025 A shared package lshift_pkg SHALL hold the default WIDTH constant and a shift-amount typedef.
REQ-026 One sub-module, lshift_stage, SHALL implement a single conditional fixed-distance shift stage (amount, enable, rotate select). lshift_4 SHALL instantiate SHW of these stages plus the output registers.

Verification
REQ-027 A=0x3, shl=2, in_valid=1 -> one cycle later: OUT=0xC, spill=0x0, zero=0, out_valid=1.
REQ-028 A=0xF, shl=3 -> OUT=0x8, spill=0x7; A=0x9, shl=0 -> OUT=0x9, spill=0x0.
REQ-029 A=0x8, shl=1 -> OUT=0x0, zero=1, spill=0x1.
REQ-030 reset asserted together with in_valid=1 and A=0x5 -> next cycle: OUT=0, out_valid=0, zero=1.
REQ-031 Three consecutive valid inputs (0x1/1, 0x2/2, 0x7/3) -> outputs 0x2, 0x8, 0x8 on consecutive cycles. Then drop in_valid for two cycles -> OUT holds 0x8 and out_valid=0.
REQ-032 With LSHIFT_4_ROTATE_EN defined: A=0x9, shl=1, rot=1 -> OUT=0x3, spill=0x1.
